cnn_layer_seq_fsm: RTL
======================

Name: cnn_layer_seq_fsm

Overview:
Parametrised successor to the single-layer tiled-CNN main controller. Sequences a full multi-layer network: per-layer config handshake, ifmap/weight/ofmap double-buffer switches, MAC enable windows and output drains. It owns the oc1 and oy1*ox1 tile counters internally instead of taking external iter-done flags. A programmable pre-MAC bubble replaces the fixed single NOP. Sits between the host config interface and the buffer controllers and MAC array.

Parameters:
CNT_W, 16, width of tile-count config fields and internal tile counters
LAYER_W, 4, width of layer index; max 2**LAYER_W layers
NOP_W, 3, width of the pre-MAC bubble length field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse in IDLE; latches num_layers, begins layer 0
num_layers  in  LAYER_W  layers to run minus 1
abort  in  1  synchronous soft abort; forces IDLE next cycle from any state
layer_params_vld  in  1  host config valid for current layer
cfg_oc1_m1  in  CNT_W  oc1 tiles minus 1
cfg_oyox_m1  in  CNT_W  oy1*ox1 tiles minus 1
cfg_nop_cycles  in  NOP_W  bubble cycles before each MAC window after an ifmap switch (0 allowed)
ic1_fy_fx_iter_done  in  1  MAC window complete
ifmap_write_bank_ready_to_switch  in  1  ifmap fill done
weight_write_bank_ready_to_switch  in  1  weight fill done
ofmap_read_bank_ready_to_switch  in  1  previous ofmap drained
layer_params_rdy  out  1  high in CONFIG
ifmap_ready_to_switch  out  1  1-cycle pulse
ifmap_start_new_write_bank  out  1  1-cycle pulse
ofmap_ready_to_switch  out  1  1-cycle pulse
ofmap_start_new_read_bank  out  1  1-cycle pulse
en_oy0_ox0_counter  out  1  high in MAC_ON
en_mac_op  out  1  high in MAC_ON
rst_n_mac  out  1  low in DRAIN and IDLE
layer_idx  out  LAYER_W  current layer
oc1_cnt  out  CNT_W  current oc1 tile
oyox_cnt  out  CNT_W  current oy1*ox1 tile
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- All state and counters reset asynchronously; outputs are Moore decodes of state (no input-to-output comb paths).
- Reset values: state IDLE, all counters 0, all pulses 0, rst_n_mac 0, busy 0, done 0, layer_params_rdy 0.
- IDLE: start -> CONFIG; latch num_layers; layer_idx=0.
- CONFIG: layer_params_rdy=1; on layer_params_vld latch cfg_*, zero oc1_cnt/oyox_cnt -> WAIT_IN.
- WAIT_IN: needs ifmap_write_bank_ready_to_switch AND (oyox_cnt!=0 OR weight_write_bank_ready_to_switch) -> IFMAP_SW. Weights are required only for the first spatial tile of a layer.
- IFMAP_SW: ifmap_ready_to_switch pulse. If oyox_cnt==cfg_oyox_m1 (no further ifmap to prefetch) -> BUBBLE, else -> WRITE_IFMAP.
- WRITE_IFMAP: ifmap_start_new_write_bank pulse -> BUBBLE.
- BUBBLE: remains cfg_nop_cycles+1 cycles total. The +1 is the weight-buffer read latency; cfg_nop_cycles=0 reproduces the prior single NOP. Then -> MAC_ON.
- MAC_ON: en_mac_op=en_oy0_ox0_counter=1; ic1_fy_fx_iter_done -> DRAIN. Minimum 1 cycle.
- DRAIN: rst_n_mac=0; ofmap_read_bank_ready_to_switch -> OFMAP_SW.
- OFMAP_SW: ofmap_ready_to_switch pulse -> OUTPUT.
- OUTPUT: ofmap_start_new_read_bank pulse, then:
  - oc1_cnt<cfg_oc1_m1: oc1_cnt++ -> MAC_ON. No bubble, since weights stream without a switch.
  - Else oc1_cnt=0; if oyox_cnt<cfg_oyox_m1: oyox_cnt++ -> WAIT_IN.
  - Else, if layer_idx<num_layers: layer_idx++ -> CONFIG.
  - Else -> DONE.
- DONE: done=1; start -> CONFIG with layer_idx=0 and new num_layers; abort -> IDLE.
- abort has priority over every transition: next state IDLE, counters cleared, no pulse emitted that cycle.
- start is ignored outside IDLE/DONE. Inputs not named in a state's transition are ignored in that state.
- Counters never wrap: compare-and-clear at _m1 bound. All-ones config values are legal.
- Async reset mid-operation: immediate IDLE; no pulse is issued on the release edge.

Decomposition:
- Package cnn_ctrl_pkg: state enum (IDLE, CONFIG, WAIT_IN, IFMAP_SW, WRITE_IFMAP, BUBBLE, MAC_ON, DRAIN, OFMAP_SW, OUTPUT, DONE); default CNT_W/LAYER_W/NOP_W constants.
- One sub-module: tile_loop_counter. It holds the nested oc1/oyox/layer counters with bound compare and outputs last_oc1, last_oyox and last_layer flags. The FSM instantiates it once.

Test Plan:
- 1 layer, oc1_m1=0, oyox_m1=0, nop=0: states run IFMAP_SW -> BUBBLE(1 cycle) -> MAC_ON, with no WRITE_IFMAP pulse; done after 1 OUTPUT pulse.
- 1 layer, oc1_m1=2, oyox_m1=1, nop=2: 6 OUTPUT pulses, 2 ifmap switches, 1 WRITE_IFMAP pulse, each BUBBLE lasts 3 cycles; WAIT_IN ignores weight_ready on tile 1.
- num_layers=2 (3 layers): layer_params_rdy asserted 3 times; layer_idx steps 0,1,2; done asserted after the last layer; a second start reruns the sequence.
- Hold ofmap_read_bank_ready_to_switch low for 10 cycles in DRAIN: rst_n_mac stays 0, en_mac_op stays 0, state holds.
- abort asserted in MAC_ON mid-layer 1: IDLE next cycle, counters 0, no pulses emitted; busy falls.
- rst_n asserted asynchronously mid-BUBBLE: outputs reach reset values immediately, without waiting for a clock edge; after release, the state stays IDLE until start.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding and default widths for the multi-layer CNN sequencer.
package cnn_ctrl_pkg;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_LAYER_W = 4;
    localparam int DEF_NOP_W   = 3;

    typedef enum logic [3:0] {
        IDLE,
        CONFIG,
        WAIT_IN,
        IFMAP_SW,
        WRITE_IFMAP,
        BUBBLE,
        MAC_ON,
        DRAIN,
        OFMAP_SW,
        OUTPUT,
        DONE
    } state_t;
endpackage

// File: rtl/tile_loop_counter.sv
// tile_loop_counter: nested oc1 / oy1*ox1 / layer counters with bound flags.
module tile_loop_counter
    import cnn_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LAYER_W = DEF_LAYER_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load_layers,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic               load_cfg,
    input  logic [CNT_W-1:0]   cfg_oc1_m1,
    input  logic [CNT_W-1:0]   cfg_oyox_m1,
    input  logic               step,
    output logic [CNT_W-1:0]   oc1_cnt,
    output logic [CNT_W-1:0]   oyox_cnt,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               last_oc1,
    output logic               last_oyox,
    output logic               last_layer
);
    logic [CNT_W-1:0]   oc1_m1, oyox_m1;
    logic [LAYER_W-1:0] layer_m1;

    assign last_oc1   = oc1_cnt == oc1_m1;
    assign last_oyox  = oyox_cnt == oyox_m1;
    assign last_layer = layer_idx == layer_m1;

    // Compare-and-clear at the bound, so all-ones bounds never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc1_cnt   <= '0;
            oyox_cnt  <= '0;
            layer_idx <= '0;
            oc1_m1    <= '0;
            oyox_m1   <= '0;
            layer_m1  <= '0;
        end else if (clr) begin
            oc1_cnt   <= '0;
            oyox_cnt  <= '0;
            layer_idx <= '0;
        end else begin
            if (load_layers) begin
                layer_m1  <= num_layers;
                layer_idx <= '0;
            end
            if (load_cfg) begin
                oc1_m1   <= cfg_oc1_m1;
                oyox_m1  <= cfg_oyox_m1;
                oc1_cnt  <= '0;
                oyox_cnt <= '0;
            end
            if (step) begin
                oc1_cnt <= last_oc1 ? '0 : oc1_cnt + 1'b1;
                if (last_oc1 && !last_oyox) oyox_cnt <= oyox_cnt + 1'b1;
                if (last_oc1 && last_oyox && !last_layer) layer_idx <= layer_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cnn_layer_seq_fsm.sv
// cnn_layer_seq_fsm: multi-layer tiled-CNN controller sequencing config,
// buffer switches, MAC windows and output drains.
module cnn_layer_seq_fsm
    import cnn_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LAYER_W = DEF_LAYER_W,
    parameter int NOP_W   = DEF_NOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic               abort,
    input  logic               layer_params_vld,
    input  logic [CNT_W-1:0]   cfg_oc1_m1,
    input  logic [CNT_W-1:0]   cfg_oyox_m1,
    input  logic [NOP_W-1:0]   cfg_nop_cycles,
    input  logic               ic1_fy_fx_iter_done,
    input  logic               ifmap_write_bank_ready_to_switch,
    input  logic               weight_write_bank_ready_to_switch,
    input  logic               ofmap_read_bank_ready_to_switch,
    output logic               layer_params_rdy,
    output logic               ifmap_ready_to_switch,
    output logic               ifmap_start_new_write_bank,
    output logic               ofmap_ready_to_switch,
    output logic               ofmap_start_new_read_bank,
    output logic               en_oy0_ox0_counter,
    output logic               en_mac_op,
    output logic               rst_n_mac,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [CNT_W-1:0]   oc1_cnt,
    output logic [CNT_W-1:0]   oyox_cnt,
    output logic               busy,
    output logic               done
);
    state_t           state, state_nx;
    logic [NOP_W-1:0] nop_cnt, nop_len;
    logic             last_oc1, last_oyox, last_layer;
    logic             start_go, cfg_go, step;

    assign start_go = start && !abort && (state == IDLE || state == DONE);
    assign cfg_go   = state == CONFIG && layer_params_vld && !abort;
    assign step     = state == OUTPUT && !abort;

    tile_loop_counter #(.CNT_W(CNT_W), .LAYER_W(LAYER_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (abort),
        .load_layers(start_go),
        .num_layers (num_layers),
        .load_cfg   (cfg_go),
        .cfg_oc1_m1 (cfg_oc1_m1),
        .cfg_oyox_m1(cfg_oyox_m1),
        .step       (step),
        .oc1_cnt    (oc1_cnt),
        .oyox_cnt   (oyox_cnt),
        .layer_idx  (layer_idx),
        .last_oc1   (last_oc1),
        .last_oyox  (last_oyox),
        .last_layer (last_layer)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (start) state_nx = CONFIG;
            CONFIG:      if (layer_params_vld) state_nx = WAIT_IN;
            // Weights are only needed before the first spatial tile of a layer.
            WAIT_IN:     if (ifmap_write_bank_ready_to_switch &&
                             (oyox_cnt != '0 || weight_write_bank_ready_to_switch)) state_nx = IFMAP_SW;
            IFMAP_SW:    state_nx = last_oyox ? BUBBLE : WRITE_IFMAP;
            WRITE_IFMAP: state_nx = BUBBLE;
            BUBBLE:      if (nop_cnt == nop_len) state_nx = MAC_ON;
            MAC_ON:      if (ic1_fy_fx_iter_done) state_nx = DRAIN;
            DRAIN:       if (ofmap_read_bank_ready_to_switch) state_nx = OFMAP_SW;
            OFMAP_SW:    state_nx = OUTPUT;
            OUTPUT:      state_nx = !last_oc1 ? MAC_ON : !last_oyox ? WAIT_IN : !last_layer ? CONFIG : DONE;
            DONE:        if (start) state_nx = CONFIG;
            default:     state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Outputs are registered from the next state, so they track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= IDLE;
            nop_cnt                    <= '0;
            nop_len                    <= '0;
            layer_params_rdy           <= 1'b0;
            ifmap_ready_to_switch      <= 1'b0;
            ifmap_start_new_write_bank <= 1'b0;
            ofmap_ready_to_switch      <= 1'b0;
            ofmap_start_new_read_bank  <= 1'b0;
            en_oy0_ox0_counter         <= 1'b0;
            en_mac_op                  <= 1'b0;
            rst_n_mac                  <= 1'b0;
            busy                       <= 1'b0;
            done                       <= 1'b0;
        end else begin
            state                      <= state_nx;
            nop_cnt                    <= (state == BUBBLE) ? nop_cnt + 1'b1 : '0;
            nop_len                    <= cfg_go ? cfg_nop_cycles : nop_len;
            layer_params_rdy           <= state_nx == CONFIG;
            ifmap_ready_to_switch      <= state_nx == IFMAP_SW;
            ifmap_start_new_write_bank <= state_nx == WRITE_IFMAP;
            ofmap_ready_to_switch      <= state_nx == OFMAP_SW;
            ofmap_start_new_read_bank  <= state_nx == OUTPUT;
            en_oy0_ox0_counter         <= state_nx == MAC_ON;
            en_mac_op                  <= state_nx == MAC_ON;
            rst_n_mac                  <= !(state_nx == IDLE || state_nx == DRAIN);
            busy                       <= !(state_nx == IDLE || state_nx == DONE);
            done                       <= state_nx == DONE;
        end
    end
endmodule
